idi_pkt_framer: RTL and testbench
=================================

IDI_PKT_FRAMER -- requirements
Module: idi_pkt_framer

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 16, meaning output FIFO entries (power of two, 4..64).
REQ-002 SHALL have the following ports, one per line as name, direction, width, meaning:
- clk_data  in  1  sole clock.
- rst  in  1  synchronous active-high reset.
- header_en, data_en  in  1 each  IDI header/payload strobes, no backpressure.
- csi_data  in  64  payload beat.
- byte_en  in  3  last valid byte index of the beat.
- data_type  in  6  packet data type.
- virtual_channel  in  4  VC.
- world_count  in  16  packet word (byte) count.
- ecc  in  8  header ECC.
- out_valid  out  1  output beat available.
- out_ready  in  1  sink accepts beat.
- out_data  out  64  beat data.
- out_keep  out  8  byte-valid mask.
- out_sop, out_eop, out_err  out  1 each  first beat, last beat, truncated packet.
- out_vc  out  4  VC.
- out_dt  out  6  data type.
- err_wc, err_ovf, err_ecc  out  1 each  single-cycle error pulses.
- pkt_cnt  out  16  count of eop beats written.

Function
REQ-003 FSM states IDLE and PAYLOAD; reset state IDLE.
REQ-004 header_en with data_type < 6'h10 (short packet): push one beat, data = {48'h0, world_count}, keep 8'h03, sop=eop=1; stay IDLE.
REQ-005 header_en with long data_type and world_count = 0: push one beat, keep 8'h00, sop=eop=1; stay IDLE.
REQ-006 header_en with long data_type and world_count > 0: latch dt/vc, set remaining = world_count, go to PAYLOAD; push nothing.
REQ-007 Each data_en in PAYLOAD pushes csi_data; sop on first beat; remaining -= 8 (saturating at 0).
REQ-008 Beat with remaining <= 8 sets eop and keep = (wc%8==0) ? 8'hFF : (1<<wc%8)-1; all earlier beats keep 8'hFF; return to IDLE.
REQ-009 On the eop beat, byte_en != (world_count-1)%8 SHALL pulse err_wc; keep still derives from world_count.
REQ-010 data_en in IDLE: beat discarded, err_wc pulse.
REQ-011 header_en in PAYLOAD: push terminator beat (keep 0, eop=1, err=1), pulse err_wc. The new header then processes as a long packet per REQ-006; a new short packet is discarded.
REQ-012 header_en and data_en in the same cycle: header processed, data discarded, err_wc pulse.
REQ-013 Push with FIFO full: beat dropped, err_ovf pulse; FSM/remaining advance as if pushed.
REQ-014 Input registered once before FIFO write; out_valid rises 2 cycles after the pushing strobe when FIFO was empty.
REQ-015 Pop on out_valid && out_ready; out_* hold stable while out_valid && !out_ready.
REQ-016 pkt_cnt increments per eop beat actually written; wraps 16'hFFFF -> 0.

Reset
REQ-017 On rst: FSM IDLE, FIFO empty, out_valid=0, all err pulses 0, pkt_cnt=0, remaining=0; out_data/keep/sop/eop/err/vc/dt = 0.
REQ-018 rst mid-packet discards partial packet; no terminator beat.

Configuration
REQ-019 With IDI_PKT_FRAMER_ECC_CHK_EN defined: compute CSI-2 6-bit ECC over {world_count, virtual_channel[1:0], data_type}; mismatch with ecc[5:0] pulses err_ecc and drops the header (REQ-004..006 not applied; following data_en beats hit REQ-010).
REQ-020 Without IDI_PKT_FRAMER_ECC_CHK_EN: no check logic; err_ecc tied 0.

Structure
REQ-021 Package idi_pkt_pkg holds state enum, beat struct {data, keep, sop, eop, err, vc, dt}, constant DT_SHORT_MAX = 6'h0F.
REQ-022 Sub-module idi_pkt_fifo: synchronous FIFO of beat structs, depth FIFO_DEPTH, full/empty flags.

Verification
REQ-023 Short packet dt=6'h00, wc=16'h0005 -> one beat data=64'h5, keep 8'h03, sop=eop=1, pkt_cnt=1.
REQ-024 Long dt=6'h2B, vc=4'h3, wc=20, 3 data_en, byte_en=3 on last -> 3 beats, keep FF,FF,0F, sop beat 0, eop beat 2, no errors.
REQ-025 Same header, byte_en=7 on last beat -> err_wc pulse on that beat; output identical to REQ-024.
REQ-026 wc=24, header_en after 1 data beat -> beat0 keep FF, terminator keep 00 eop=1 err=1, err_wc pulse.
REQ-027 out_ready=0 held, 20 short packets, FIFO_DEPTH=16 -> 16 stored, 4 err_ovf pulses, pkt_cnt=16.
REQ-028 With ECC macro, header with ecc[5:0] flipped -> err_ecc pulse, nothing pushed, next data_en -> err_wc.

Source files
------------

// File: rtl/idi_pkt_pkg.sv
// Shared types, constants and the CSI-2 header ECC helper for the IDI packet framer.
package idi_pkt_pkg;

    localparam logic [5:0] DT_SHORT_MAX = 6'h0F;

    typedef enum logic {
        IDLE    = 1'b0,
        PAYLOAD = 1'b1
    } state_t;

    typedef struct packed {
        logic [63:0] data;
        logic [7:0]  keep;
        logic        sop;
        logic        eop;
        logic        err;
        logic [3:0]  vc;
        logic [5:0]  dt;
    } beat_t;

    // CSI-2 Hamming parity over {word_count, vc[1:0], data_type}; each mask selects the data bits of one parity bit.
    function automatic logic [5:0] csi2_ecc(input logic [23:0] d);
        logic [5:0] p;
        p[0] = ^(d & 24'hF12CB7);
        p[1] = ^(d & 24'hF2555B);
        p[2] = ^(d & 24'h749A6D);
        p[3] = ^(d & 24'hB8E38E);
        p[4] = ^(d & 24'hDF03F0);
        p[5] = ^(d & 24'hEFFC00);
        return p;
    endfunction

endpackage

// File: rtl/idi_pkt_fifo.sv
// Synchronous FIFO of framed beats; the storage array carries no reset, only the pointers do.
module idi_pkt_fifo
    import idi_pkt_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic  clk_data,
    input  logic  rst,
    input  logic  wr_en,
    input  beat_t wr_beat,
    input  logic  rd_en,
    output beat_t rd_beat,
    output logic  full,
    output logic  empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    beat_t       mem_q [DEPTH];
    logic        do_wr;
    logic        do_rd;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_wr = wr_en && !full;
    assign do_rd = rd_en && !empty;

    assign rd_beat = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_wr) begin
            wr_ptr_d = wr_ptr_q + (AW+1)'(1);
        end
        if (do_rd) begin
            rd_ptr_d = rd_ptr_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk_data) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk_data) begin
        if (do_wr) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wr_beat;
        end
    end

endmodule

// File: rtl/idi_pkt_framer.sv
// Frames IDI header/payload strobes into keep-masked beats buffered in an output FIFO.
// Optional header ECC checking is enabled by defining IDI_PKT_FRAMER_ECC_CHK_EN.
module idi_pkt_framer
    import idi_pkt_pkg::*;
#(
    parameter int FIFO_DEPTH = 16
) (
    input  logic        clk_data,
    input  logic        rst,
    input  logic        header_en,
    input  logic        data_en,
    input  logic [63:0] csi_data,
    input  logic [2:0]  byte_en,
    input  logic [5:0]  data_type,
    input  logic [3:0]  virtual_channel,
    input  logic [15:0] world_count,
    input  logic [7:0]  ecc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_data,
    output logic [7:0]  out_keep,
    output logic        out_sop,
    output logic        out_eop,
    output logic        out_err,
    output logic [3:0]  out_vc,
    output logic [5:0]  out_dt,
    output logic        err_wc,
    output logic        err_ovf,
    output logic        err_ecc,
    output logic [15:0] pkt_cnt
);

    function automatic logic [7:0] last_keep(input logic [2:0] r);
        return (r == 3'd0) ? 8'hFF : ((8'd1 << r) - 8'd1);
    endfunction

    function automatic logic [15:0] sat_sub8(input logic [15:0] r);
        return (r > 16'd8) ? (r - 16'd8) : 16'd0;
    endfunction

    state_t      state_q, state_d;
    logic [15:0] rem_q, rem_d;
    logic        first_q, first_d;
    logic [3:0]  vc_q, vc_d;
    logic [5:0]  dt_q, dt_d;
    logic        push_d;
    beat_t       beat_d;
    logic        err_wc_d, err_ecc_d;
    logic        hdr_ok;
    logic        is_short;
    logic        is_last;

    logic        push_p0_q;
    beat_t       beat_p0_q;
    logic        err_wc_q, err_ecc_q;
    logic        err_ovf_q, err_ovf_d;
    logic [15:0] pkt_cnt_q, pkt_cnt_d;

    logic        fifo_full, fifo_empty, fifo_rd;
    beat_t       fifo_beat;

`ifdef IDI_PKT_FRAMER_ECC_CHK_EN
    logic unused_ecc;
    assign unused_ecc = ^ecc[7:6];
    assign hdr_ok = header_en &&
                    (ecc[5:0] == csi2_ecc({world_count, virtual_channel[1:0], data_type}));
`else
    logic unused_ecc;
    assign unused_ecc = ^ecc;
    assign hdr_ok = header_en;
`endif

    assign is_short = (data_type <= DT_SHORT_MAX);
    assign is_last  = (rem_q <= 16'd8);

    always_comb begin
        state_d   = state_q;
        rem_d     = rem_q;
        first_d   = first_q;
        vc_d      = vc_q;
        dt_d      = dt_q;
        push_d    = 1'b0;
        beat_d    = '0;
        err_wc_d  = header_en && data_en;
        err_ecc_d = header_en && !hdr_ok;

        unique case (state_q)
            IDLE: begin
                if (hdr_ok) begin
                    if (is_short) begin
                        push_d      = 1'b1;
                        beat_d.data = {48'h0, world_count};
                        beat_d.keep = 8'h03;
                        beat_d.sop  = 1'b1;
                        beat_d.eop  = 1'b1;
                        beat_d.vc   = virtual_channel;
                        beat_d.dt   = data_type;
                    end else if (world_count == 16'd0) begin
                        push_d      = 1'b1;
                        beat_d.sop  = 1'b1;
                        beat_d.eop  = 1'b1;
                        beat_d.vc   = virtual_channel;
                        beat_d.dt   = data_type;
                    end else begin
                        state_d = PAYLOAD;
                        rem_d   = world_count;
                        first_d = 1'b1;
                        vc_d    = virtual_channel;
                        dt_d    = data_type;
                    end
                end else if (data_en && !header_en) begin
                    err_wc_d = 1'b1;
                end
            end
            PAYLOAD: begin
                if (header_en) begin
                    // Close the interrupted packet; the terminator carries the old packet's vc/dt.
                    push_d     = 1'b1;
                    beat_d.sop = first_q;
                    beat_d.eop = 1'b1;
                    beat_d.err = 1'b1;
                    beat_d.vc  = vc_q;
                    beat_d.dt  = dt_q;
                    err_wc_d   = 1'b1;
                    state_d    = IDLE;
                    rem_d      = 16'd0;
                    if (hdr_ok && !is_short && (world_count != 16'd0)) begin
                        state_d = PAYLOAD;
                        rem_d   = world_count;
                        first_d = 1'b1;
                        vc_d    = virtual_channel;
                        dt_d    = data_type;
                    end
                end else if (data_en) begin
                    push_d      = 1'b1;
                    beat_d.data = csi_data;
                    beat_d.keep = is_last ? last_keep(rem_q[2:0]) : 8'hFF;
                    beat_d.sop  = first_q;
                    beat_d.eop  = is_last;
                    beat_d.vc   = vc_q;
                    beat_d.dt   = dt_q;
                    first_d     = 1'b0;
                    rem_d       = sat_sub8(rem_q);
                    // remaining stays congruent to world_count mod 8, so it yields the expected last byte index.
                    if (is_last) begin
                        state_d = IDLE;
                        if (byte_en != (rem_q[2:0] - 3'd1)) begin
                            err_wc_d = 1'b1;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_data) begin
        if (rst) begin
            state_q <= IDLE;
            rem_q   <= '0;
            first_q <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            first_q <= first_d;
        end
    end

    always_ff @(posedge clk_data) begin
        vc_q <= vc_d;
        dt_q <= dt_d;
    end

    // Stage p0: registered beat waiting for the FIFO write.
    always_ff @(posedge clk_data) begin
        if (rst) begin
            push_p0_q <= 1'b0;
            err_wc_q  <= 1'b0;
            err_ecc_q <= 1'b0;
        end else begin
            push_p0_q <= push_d;
            err_wc_q  <= err_wc_d;
            err_ecc_q <= err_ecc_d;
        end
    end

    always_ff @(posedge clk_data) begin
        beat_p0_q <= beat_d;
    end

    always_comb begin
        err_ovf_d = push_p0_q && fifo_full;
        pkt_cnt_d = pkt_cnt_q;
        if (push_p0_q && !fifo_full && beat_p0_q.eop) begin
            pkt_cnt_d = pkt_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk_data) begin
        if (rst) begin
            err_ovf_q <= 1'b0;
            pkt_cnt_q <= '0;
        end else begin
            err_ovf_q <= err_ovf_d;
            pkt_cnt_q <= pkt_cnt_d;
        end
    end

    idi_pkt_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_data (clk_data),
        .rst      (rst),
        .wr_en    (push_p0_q),
        .wr_beat  (beat_p0_q),
        .rd_en    (fifo_rd),
        .rd_beat  (fifo_beat),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    assign fifo_rd = out_valid && out_ready;

    // Stale storage is masked while empty so the outputs read zero after reset.
    always_comb begin
        out_valid = !fifo_empty;
        out_data  = '0;
        out_keep  = '0;
        out_sop   = 1'b0;
        out_eop   = 1'b0;
        out_err   = 1'b0;
        out_vc    = '0;
        out_dt    = '0;
        if (!fifo_empty) begin
            out_data = fifo_beat.data;
            out_keep = fifo_beat.keep;
            out_sop  = fifo_beat.sop;
            out_eop  = fifo_beat.eop;
            out_err  = fifo_beat.err;
            out_vc   = fifo_beat.vc;
            out_dt   = fifo_beat.dt;
        end
    end

    assign err_wc  = err_wc_q;
    assign err_ovf = err_ovf_q;
`ifdef IDI_PKT_FRAMER_ECC_CHK_EN
    assign err_ecc = err_ecc_q;
`else
    logic unused_ecc_chk;
    assign unused_ecc_chk = err_ecc_q;
    assign err_ecc = 1'b0;
`endif
    assign pkt_cnt = pkt_cnt_q;

endmodule

// File: tb/tb_idi_pkt_framer.sv
// Self-checking bench for idi_pkt_framer: vector table plus hand sequences, scoreboard on the output stream.
module tb_idi_pkt_framer;

    logic        clk_data = 1'b0;
    logic        rst;
    logic        header_en, data_en;
    logic [63:0] csi_data;
    logic [2:0]  byte_en;
    logic [5:0]  data_type;
    logic [3:0]  virtual_channel;
    logic [15:0] world_count;
    logic [7:0]  ecc;
    logic        out_valid, out_ready;
    logic [63:0] out_data;
    logic [7:0]  out_keep;
    logic        out_sop, out_eop, out_err;
    logic [3:0]  out_vc;
    logic [5:0]  out_dt;
    logic        err_wc, err_ovf, err_ecc;
    logic [15:0] pkt_cnt;

    idi_pkt_framer #(.FIFO_DEPTH(16)) dut (
        .clk_data(clk_data), .rst(rst), .header_en(header_en), .data_en(data_en),
        .csi_data(csi_data), .byte_en(byte_en), .data_type(data_type),
        .virtual_channel(virtual_channel), .world_count(world_count), .ecc(ecc),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_keep(out_keep),
        .out_sop(out_sop), .out_eop(out_eop), .out_err(out_err), .out_vc(out_vc), .out_dt(out_dt),
        .err_wc(err_wc), .err_ovf(err_ovf), .err_ecc(err_ecc), .pkt_cnt(pkt_cnt)
    );

    always #5 clk_data = ~clk_data;

    typedef struct {
        logic [63:0] data;
        logic [7:0]  keep;
        logic        sop, eop, err;
        logic [3:0]  vc;
        logic [5:0]  dt;
    } exp_t;

    typedef struct {
        logic [5:0]  dt;
        logic [3:0]  vc;
        logic [15:0] wc;
        logic [2:0]  be_last;
        int          exp_wc_err;
    } vec_t;

    exp_t        q[$];
    vec_t        vecs[8];
    int          n_checks = 0;
    int          n_errors = 0;
    int          cnt_wc = 0, cnt_ovf = 0, cnt_ecc = 0;
    logic [15:0] exp_pkt = 16'd0;
    logic        rdy_force = 1'b1, rdy_val = 1'b1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] calc_ecc(input logic [5:0] dt, input logic [3:0] vc, input logic [15:0] wc);
        logic [23:0] d;
        logic [5:0]  p;
        d = {wc, vc[1:0], dt};
        p[0] = d[0]^d[1]^d[2]^d[4]^d[5]^d[7]^d[10]^d[11]^d[13]^d[16]^d[20]^d[21]^d[22]^d[23];
        p[1] = d[0]^d[1]^d[3]^d[4]^d[6]^d[8]^d[10]^d[12]^d[14]^d[17]^d[20]^d[21]^d[22]^d[23];
        p[2] = d[0]^d[2]^d[3]^d[5]^d[6]^d[9]^d[11]^d[12]^d[15]^d[18]^d[20]^d[21]^d[22];
        p[3] = d[1]^d[2]^d[3]^d[7]^d[8]^d[9]^d[13]^d[14]^d[15]^d[19]^d[20]^d[21]^d[23];
        p[4] = d[4]^d[5]^d[6]^d[7]^d[8]^d[9]^d[16]^d[17]^d[18]^d[19]^d[20]^d[22]^d[23];
        p[5] = d[10]^d[11]^d[12]^d[13]^d[14]^d[15]^d[16]^d[17]^d[18]^d[19]^d[21]^d[22]^d[23];
        return {2'b00, p};
    endfunction

    task automatic push_exp(input logic [63:0] d, input logic [7:0] k, input logic s, input logic e,
                            input logic er, input logic [3:0] vc, input logic [5:0] dt);
        exp_t x;
        x.data = d; x.keep = k; x.sop = s; x.eop = e; x.err = er; x.vc = vc; x.dt = dt;
        q.push_back(x);
        if (e) exp_pkt = exp_pkt + 16'd1;
    endtask

    task automatic drv(input logic h, input logic d, input logic [5:0] dt, input logic [3:0] vc,
                       input logic [15:0] wc, input logic [63:0] dat, input logic [2:0] be, input logic bad);
        @(negedge clk_data);
        header_en = h; data_en = d; data_type = dt; virtual_channel = vc;
        world_count = wc; csi_data = dat; byte_en = be;
        ecc = calc_ecc(dt, vc, wc) ^ (bad ? 8'h01 : 8'h00);
    endtask

    task automatic idle_cyc(input int n);
        repeat (n) begin
            @(negedge clk_data);
            header_en = 1'b0; data_en = 1'b0;
        end
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (q.size() != 0 && k < 300) begin
            @(negedge clk_data);
            header_en = 1'b0; data_en = 1'b0;
            k++;
        end
        if (q.size() != 0) begin
            n_checks++; n_errors++;
            $display("FAIL drain_timeout: %0d beats still expected", q.size());
            q.delete();
        end
        idle_cyc(3);
        chk("drain_valid_low", out_valid, 1'b0);
    endtask

    task automatic send_vec(input vec_t v);
        int          nb, r;
        logic [63:0] d;
        logic [7:0]  kp;
        logic        last;
        drv(1'b1, 1'b0, v.dt, v.vc, v.wc, 64'h0, 3'd0, 1'b0);
        if (v.dt < 6'h10) begin
            push_exp({48'h0, v.wc}, 8'h03, 1'b1, 1'b1, 1'b0, v.vc, v.dt);
        end else if (v.wc == 16'd0) begin
            push_exp(64'h0, 8'h00, 1'b1, 1'b1, 1'b0, v.vc, v.dt);
        end else begin
            nb = (int'(v.wc) + 7) / 8;
            r  = int'(v.wc) % 8;
            for (int i = 0; i < nb; i++) begin
                d    = {$urandom, $urandom};
                last = (i == nb - 1);
                drv(1'b0, 1'b1, 6'h3F, 4'hF, 16'hFFFF, d, last ? v.be_last : 3'd7, 1'b0);
                kp = (!last || r == 0) ? 8'hFF : 8'((1 << r) - 1);
                push_exp(d, kp, i == 0, last, 1'b0, v.vc, v.dt);
            end
        end
        idle_cyc(1);
    endtask

    // Ready driver: random backpressure unless forced.
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk_data);
            #1;
            out_ready = rdy_force ? rdy_val : ($urandom_range(0, 3) != 0);
        end
    end

    // Output monitor: scoreboard pop, hold-stability and error-pulse counting.
    initial begin
        exp_t        e;
        logic        hold_pend;
        logic [63:0] held_data;
        logic [21:0] held_meta;
        hold_pend = 1'b0;
        held_data = '0;
        held_meta = '0;
        forever begin
            @(negedge clk_data);
            if (rst) begin
                hold_pend = 1'b0;
            end else begin
                if (err_wc)  cnt_wc++;
                if (err_ovf) cnt_ovf++;
                if (err_ecc) cnt_ecc++;
                if (hold_pend) begin
                    chk("hold_data", out_data, held_data);
                    chk("hold_meta", {out_valid, out_keep, out_sop, out_eop, out_err, out_vc, out_dt}, held_meta);
                end
                if (out_valid && out_ready) begin
                    if (q.size() == 0) begin
                        n_checks++; n_errors++;
                        $display("FAIL unexpected_beat: got data %h keep %h, expected none", out_data, out_keep);
                    end else begin
                        e = q.pop_front();
                        chk("beat_data", out_data, e.data);
                        chk("beat_meta", {out_keep, out_sop, out_eop, out_err, out_vc, out_dt},
                            {e.keep, e.sop, e.eop, e.err, e.vc, e.dt});
                    end
                end
                hold_pend = out_valid && !out_ready;
                held_data = out_data;
                held_meta = {out_valid, out_keep, out_sop, out_eop, out_err, out_vc, out_dt};
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int b_wc, b_ovf, b_ecc;
        rst = 1'b1; header_en = 1'b0; data_en = 1'b0; csi_data = '0; byte_en = '0;
        data_type = '0; virtual_channel = '0; world_count = '0; ecc = '0;

        vecs[0] = '{6'h00, 4'h0, 16'd5,      3'd0, 0};
        vecs[1] = '{6'h2B, 4'h3, 16'd20,     3'd3, 0};
        vecs[2] = '{6'h2B, 4'h3, 16'd20,     3'd7, 1};
        vecs[3] = '{6'h2A, 4'h6, 16'd0,      3'd0, 0};
        vecs[4] = '{6'h1E, 4'h1, 16'd8,      3'd7, 0};
        vecs[5] = '{6'h24, 4'h2, 16'd17,     3'd0, 0};
        vecs[6] = '{6'h0F, 4'h5, 16'hABCD,   3'd0, 0};
        vecs[7] = '{6'h10, 4'h9, 16'd1,      3'd0, 0};

        // Reset state.
        repeat (3) @(negedge clk_data);
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_data", out_data, 64'h0);
        chk("rst_meta", {out_keep, out_sop, out_eop, out_err, out_vc, out_dt}, 21'h0);
        chk("rst_pulses", {err_wc, err_ovf, err_ecc}, 3'b000);
        chk("rst_pkt_cnt", pkt_cnt, 16'h0);
        rst = 1'b0;
        rdy_force = 1'b0;

        // Table-driven packets with random backpressure.
        for (int i = 0; i < 8; i++) begin
            b_wc = cnt_wc;
            send_vec(vecs[i]);
            drain();
            chk($sformatf("vec%0d_err_wc", i), cnt_wc - b_wc, vecs[i].exp_wc_err);
            chk($sformatf("vec%0d_pkt_cnt", i), pkt_cnt, exp_pkt);
        end

        // Header mid-packet: terminator, then the new long header continues; then a short header mid-packet.
        begin
            logic [63:0] d0, d1;
            b_wc = cnt_wc;
            d0 = {$urandom, $urandom};
            d1 = {$urandom, $urandom};
            drv(1'b1, 1'b0, 6'h2B, 4'h3, 16'd24, 64'h0, 3'd0, 1'b0);
            drv(1'b0, 1'b1, 6'h00, 4'h0, 16'h0, d0, 3'd7, 1'b0);
            push_exp(d0, 8'hFF, 1'b1, 1'b0, 1'b0, 4'h3, 6'h2B);
            drv(1'b1, 1'b0, 6'h2C, 4'h4, 16'd8, 64'h0, 3'd0, 1'b0);
            push_exp(64'h0, 8'h00, 1'b0, 1'b1, 1'b1, 4'h3, 6'h2B);
            drv(1'b0, 1'b1, 6'h00, 4'h0, 16'h0, d1, 3'd7, 1'b0);
            push_exp(d1, 8'hFF, 1'b1, 1'b1, 1'b0, 4'h4, 6'h2C);
            idle_cyc(1);
            drain();
            chk("hdr_in_payload_err_wc", cnt_wc - b_wc, 1);
            b_wc = cnt_wc;
            drv(1'b1, 1'b0, 6'h30, 4'h7, 16'd16, 64'h0, 3'd0, 1'b0);
            drv(1'b1, 1'b0, 6'h02, 4'h1, 16'd9, 64'h0, 3'd0, 1'b0);
            push_exp(64'h0, 8'h00, 1'b1, 1'b1, 1'b1, 4'h7, 6'h30);
            drv(1'b0, 1'b1, 6'h00, 4'h0, 16'h0, d1, 3'd0, 1'b0);
            idle_cyc(1);
            drain();
            chk("short_hdr_in_payload_err_wc", cnt_wc - b_wc, 2);
            chk("term_pkt_cnt", pkt_cnt, exp_pkt);
        end

        // Data strobe while idle, and header+data in the same cycle.
        b_wc = cnt_wc;
        drv(1'b0, 1'b1, 6'h00, 4'h0, 16'h0, 64'hDEAD, 3'd7, 1'b0);
        idle_cyc(2);
        drv(1'b1, 1'b1, 6'h02, 4'h1, 16'd7, 64'hBEEF, 3'd6, 1'b0);
        push_exp(64'd7, 8'h03, 1'b1, 1'b1, 1'b0, 4'h1, 6'h02);
        idle_cyc(1);
        drain();
        chk("idle_data_and_collision_err_wc", cnt_wc - b_wc, 2);

        // Overflow: sink stalled, 20 short packets into 16 entries.
        rdy_force = 1'b1; rdy_val = 1'b0;
        idle_cyc(2);
        b_ovf = cnt_ovf;
        for (int i = 0; i < 20; i++) begin
            drv(1'b1, 1'b0, 6'h01, 4'h2, 16'(100 + i), 64'h0, 3'd0, 1'b0);
            if (i < 16) push_exp(64'(100 + i), 8'h03, 1'b1, 1'b1, 1'b0, 4'h2, 6'h01);
        end
        idle_cyc(4);
        chk("ovf_pulses", cnt_ovf - b_ovf, 4);
        chk("ovf_pkt_cnt", pkt_cnt, exp_pkt);
        chk("ovf_valid", out_valid, 1'b1);
        chk("ovf_head_data", out_data, 64'd100);
        rdy_force = 1'b0;
        drain();

        // Reset mid-packet discards the partial packet without a terminator.
        drv(1'b1, 1'b0, 6'h2B, 4'h3, 16'd24, 64'h0, 3'd0, 1'b0);
        drv(1'b0, 1'b1, 6'h00, 4'h0, 16'h0, 64'h1234, 3'd7, 1'b0);
        @(negedge clk_data);
        rst = 1'b1; header_en = 1'b0; data_en = 1'b0;
        q.delete();
        exp_pkt = 16'd0;
        repeat (2) @(negedge clk_data);
        rst = 1'b0;
        idle_cyc(3);
        chk("midrst_valid", out_valid, 1'b0);
        chk("midrst_pkt_cnt", pkt_cnt, 16'h0);
        b_wc = cnt_wc;
        drv(1'b0, 1'b1, 6'h00, 4'h0, 16'h0, 64'h55, 3'd7, 1'b0);
        idle_cyc(2);
        chk("midrst_idle_err_wc", cnt_wc - b_wc, 1);
        send_vec(vecs[0]);
        drain();
        chk("midrst_pkt_cnt_after", pkt_cnt, exp_pkt);

`ifdef IDI_PKT_FRAMER_ECC_CHK_EN
        // Corrupted header ECC: header dropped, following data hits idle.
        b_wc = cnt_wc; b_ecc = cnt_ecc;
        drv(1'b1, 1'b0, 6'h2B, 4'h3, 16'd16, 64'h0, 3'd0, 1'b1);
        drv(1'b0, 1'b1, 6'h00, 4'h0, 16'h0, 64'h77, 3'd7, 1'b0);
        idle_cyc(1);
        drain();
        chk("ecc_err_pulse", cnt_ecc - b_ecc, 1);
        chk("ecc_drop_err_wc", cnt_wc - b_wc, 1);
        chk("ecc_drop_pkt_cnt", pkt_cnt, exp_pkt);
`else
        // ECC content ignored: a header with a wrong ecc is framed normally.
        b_ecc = cnt_ecc;
        drv(1'b1, 1'b0, 6'h03, 4'h8, 16'h0042, 64'h0, 3'd0, 1'b1);
        push_exp(64'h42, 8'h03, 1'b1, 1'b1, 1'b0, 4'h8, 6'h03);
        idle_cyc(1);
        drain();
        chk("no_ecc_pulse", cnt_ecc - b_ecc, 0);
        chk("no_ecc_pkt_cnt", pkt_cnt, exp_pkt);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
